// File: rtl/bus_ack_pkg.sv
// Shared types for the 68000 bus-cycle termination controller.
package bus_ack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    EXTWAIT,
    ACK,
    ERR,
    AUTOVEC
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DUART,
    SRC_EXP
  } src_t;

  localparam logic [2:0] FC_IACK = 3'b111;

  // The timeout window only runs while a cycle is waiting for its terminator.
  function automatic logic is_waiting(input state_t s);
    return (s == WAIT) || (s == EXTWAIT);
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter; expired goes high once TIMEOUT-1 edges have been counted.
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/bus_ack_controller.sv
// Generates DTACK/BERR/VPA for the 68000 bus: per-region wait states, external
// peripheral acknowledge forwarding, IACK autovectoring and a bus-error timeout.
module bus_ack_controller
  import bus_ack_pkg::*;
#(
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic AS,
  input  logic UDS,
  input  logic LDS,
  input  logic FC0,
  input  logic FC1,
  input  logic FC2,
  input  logic ROM_CS,
  input  logic RAM_CS,
  input  logic DUART_CS,
  input  logic EXP_CS,
  input  logic DUART_DTACK,
  input  logic EXP_DTACK,
  output logic DTACK,
  output logic BERR,
  output logic VPA
);

  localparam logic [3:0] ROM_WAIT_L = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_WAIT_L = 4'(RAM_WAIT);

  state_t     state_d, state_q;
  src_t       src_d, src_q;
  logic [3:0] wait_d, wait_q;
  logic       ext_dtack_d, ext_dtack_q;
  logic       dtack_d, dtack_q;
  logic       berr_d, berr_q;
  logic       vpa_d, vpa_q;
  logic [2:0] fc;
  logic       cycle_start;
  logic       ext_ack;
  logic       timer_clear;
  logic       expired;

  assign fc          = {FC2, FC1, FC0};
  assign cycle_start = !AS && (!UDS || !LDS || (fc == FC_IACK));
  assign ext_ack     = (src_q != SRC_NONE) && !ext_dtack_q;
  assign timer_clear = !(is_waiting(state_q) && is_waiting(state_d));

  // The peripheral acknowledge is only sampled while waiting on it, so a level left
  // over from an earlier cycle or present on the start edge is never taken as an ack.
  always_comb begin
    ext_dtack_d = 1'b1;
    if (state_q == EXTWAIT) begin
      case (src_q)
        SRC_DUART: ext_dtack_d = DUART_DTACK;
        SRC_EXP:   ext_dtack_d = EXP_DTACK;
        default:   ext_dtack_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (cycle_start) begin
          src_d  = SRC_NONE;
          wait_d = '0;
          if (fc == FC_IACK) begin
            state_d = AUTOVEC;
          end else if (!ROM_CS) begin
            state_d = WAIT;
            wait_d  = ROM_WAIT_L;
          end else if (!RAM_CS) begin
            state_d = WAIT;
            wait_d  = RAM_WAIT_L;
          end else if (!DUART_CS) begin
            state_d = EXTWAIT;
            src_d   = SRC_DUART;
          end else if (!EXP_CS) begin
            state_d = EXTWAIT;
            src_d   = SRC_EXP;
          end else begin
            state_d = EXTWAIT;
          end
        end
      end
      WAIT: begin
        if (AS) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (wait_q == 4'd0) begin
          state_d = ACK;
        end else if (expired) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      EXTWAIT: begin
        if (AS) begin
          state_d = IDLE;
          src_d   = SRC_NONE;
        end else if (ext_ack) begin
          state_d = ACK;
        end else if (expired) begin
          state_d = ERR;
        end
      end
      ACK, ERR, AUTOVEC: begin
        if (AS) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // VPA is held off for one edge after entering AUTOVEC so it falls one edge after cycle start.
  always_comb begin
    dtack_d = (state_d != ACK);
    berr_d  = (state_d != ERR);
    vpa_d   = !((state_d == AUTOVEC) && (state_q == AUTOVEC));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      src_q       <= SRC_NONE;
      wait_q      <= '0;
      ext_dtack_q <= 1'b1;
      dtack_q     <= 1'b1;
      berr_q      <= 1'b1;
      vpa_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      wait_q      <= wait_d;
      ext_dtack_q <= ext_dtack_d;
      dtack_q     <= dtack_d;
      berr_q      <= berr_d;
      vpa_q       <= vpa_d;
    end
  end

  bus_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (CLK),
    .rst_n  (RST),
    .clear  (timer_clear),
    .expired(expired)
  );

  assign DTACK = dtack_q;
  assign BERR  = berr_q;
  assign VPA   = vpa_q;

endmodule
